// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and types for the execute-stage issue block and its ALU.
package alu_issue_stage_pkg;

  // Datapath width (must match the ALU), register index width, opcode width.
  localparam int N   = 16;
  localparam int RAW = 3;
  localparam int OPW = 3;

  // Shift distance uses only the low log2(N) bits of operand b.
  localparam int SHW = $clog2(N);

  // ALU opcodes.
  localparam logic [OPW-1:0] ALU_ADD = 3'd0;
  localparam logic [OPW-1:0] ALU_SUB = 3'd1;
  localparam logic [OPW-1:0] ALU_AND = 3'd2;
  localparam logic [OPW-1:0] ALU_OR  = 3'd3;
  localparam logic [OPW-1:0] ALU_XOR = 3'd4;
  localparam logic [OPW-1:0] ALU_NOR = 3'd5;
  localparam logic [OPW-1:0] ALU_SLL = 3'd6;
  localparam logic [OPW-1:0] ALU_SRL = 3'd7;

  // Where a source operand comes from: register file, EX/MEM register, MEM/WB.
  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_WB
  } fwd_sel_e;

endpackage

// File: rtl/alu_issue_stage_alu.sv
// Combinational N-bit ALU. ADD/SUB report carry-out (SUB computes
// a + ~b + 1, so cout=1 means "no borrow", i.e. a >= b unsigned).
// Logic and shift ops report cout=0. Shifts use b[SHW-1:0] as the distance.
module alu_issue_stage_alu
  import alu_issue_stage_pkg::*;
(
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [OPW-1:0] opcode,
  output logic [N-1:0]   s,
  output logic           cout
);

  // Opcode decode and result/carry generation.
  always_comb begin
    s    = '0;
    cout = 1'b0;
    case (opcode)
      ALU_ADD: {cout, s} = {1'b0, a} + {1'b0, b};
      ALU_SUB: {cout, s} = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      ALU_XOR: s = a ^ b;
      ALU_NOR: s = ~(a | b);
      ALU_SLL: s = a << b[SHW-1:0];
      ALU_SRL: s = a >> b[SHW-1:0];
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: operand forwarding, ALU drive and the EX/MEM
// output register with valid/ready handshakes and a flush input.
// Optional macro OVERFLOW_FLAG_EN adds the out_ovf signed-overflow output.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [RAW-1:0] in_rs,
  input  logic [RAW-1:0] in_rt,
  input  logic [N-1:0]   in_rs_val,
  input  logic [N-1:0]   in_rt_val,
  input  logic [N-1:0]   in_imm,
  input  logic           in_use_imm,
  input  logic [RAW-1:0] in_rd,
  input  logic           in_wen,
  input  logic           wb_wen,
  input  logic [RAW-1:0] wb_rd,
  input  logic [N-1:0]   wb_val,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_s,
  output logic           out_cout,
  output logic           out_zero,
  output logic [RAW-1:0] out_rd,
  output logic           out_wen
`ifdef OVERFLOW_FLAG_EN
  , output logic         out_ovf
`endif
);

  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_s_q, out_s_d;
  logic           out_cout_q, out_cout_d;
  logic           out_zero_q, out_zero_d;
  logic [RAW-1:0] out_rd_q, out_rd_d;
  logic           out_wen_q, out_wen_d;

  logic           accept;
  logic [RAW-1:0] src_idx [2];
  logic [N-1:0]   src_rf  [2];
  logic [N-1:0]   fwd_val [2];
  logic [N-1:0]   alu_a, alu_b, alu_s;
  logic           alu_cout;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign src_idx[0] = in_rs;
  assign src_idx[1] = in_rt;
  assign src_rf[0]  = in_rs_val;
  assign src_rf[1]  = in_rt_val;

  // One forwarding mux per source operand; index 0 is rs, index 1 is rt.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_sel_e sel;

    // Pick the youngest producer; r0 never forwards and always reads as zero.
    always_comb begin
      sel = FWD_RF;
      if (src_idx[gi] != '0) begin
        if (out_valid_q && out_wen_q && out_rd_q == src_idx[gi]) sel = FWD_EX;
        else if (wb_wen && wb_rd == src_idx[gi])                 sel = FWD_WB;
      end
    end

    assign fwd_val[gi] = (src_idx[gi] == '0) ? '0      :
                         (sel == FWD_EX)     ? out_s_q :
                         (sel == FWD_WB)     ? wb_val  : src_rf[gi];
  end

  assign alu_a = fwd_val[0];
  assign alu_b = in_use_imm ? in_imm : fwd_val[1];

  alu_issue_stage_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .opcode (in_op),
    .s      (alu_s),
    .cout   (alu_cout)
  );

`ifdef OVERFLOW_FLAG_EN
  logic ovf_calc, out_ovf_q, out_ovf_d;

  // Signed overflow: ADD when same-sign operands give a different-sign
  // result; SUB when opposite-sign operands give a result unlike a.
  always_comb begin
    ovf_calc = 1'b0;
    if (in_op == ALU_ADD)
      ovf_calc = (alu_a[N-1] == alu_b[N-1]) && (alu_s[N-1] != alu_a[N-1]);
    else if (in_op == ALU_SUB)
      ovf_calc = (alu_a[N-1] != alu_b[N-1]) && (alu_s[N-1] != alu_a[N-1]);
  end
`endif

  // EX/MEM next state: flush beats accept, consume clears, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_cout_d  = out_cout_q;
    out_zero_d  = out_zero_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
`ifdef OVERFLOW_FLAG_EN
    out_ovf_d   = out_ovf_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_s_d     = alu_s;
      out_cout_d  = alu_cout;
      out_zero_d  = (alu_s == '0);
      out_rd_d    = in_rd;
      out_wen_d   = in_wen;
`ifdef OVERFLOW_FLAG_EN
      out_ovf_d   = ovf_calc;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // EX/MEM register with asynchronous reset; a reset drops any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
      out_zero_q  <= 1'b1;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_cout_q  <= out_cout_d;
      out_zero_q  <= out_zero_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
`ifdef OVERFLOW_FLAG_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_zero  = out_zero_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;
`ifdef OVERFLOW_FLAG_EN
  assign out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the stimulus side predicts each
// accepted op with a behavioural model and queues it; a monitor compares
// every result the DUT hands downstream (out_valid && out_ready).
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_rs_val = '0, in_rt_val = '0, in_imm = '0;
  logic        in_use_imm = 1'b0, in_wen = 1'b0;
  logic        wb_wen = 1'b0;
  logic [2:0]  wb_rd = '0;
  logic [15:0] wb_val = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_s;
  logic        out_cout, out_zero, out_wen;
  logic [2:0]  out_rd;
`ifdef OVERFLOW_FLAG_EN
  logic        out_ovf;
`endif

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wen(in_wen),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_val(wb_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_cout(out_cout), .out_zero(out_zero), .out_rd(out_rd), .out_wen(out_wen)
`ifdef OVERFLOW_FLAG_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        zero;
    logic [2:0]  rd;
    logic        wen;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model of what currently sits in EX/MEM (a plain record, not the RTL).
  logic        m_valid = 1'b0;
  exp_t        m_res;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Behavioural ALU: plain integer arithmetic on the operand values.
  function automatic exp_t alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int unsigned sum;
    int sa, sb, sr;
    logic [3:0] sh;
    sh = b[3:0];
    sa = $signed(a);
    sb = $signed(b);
    r.s = '0; r.cout = 1'b0; r.ovf = 1'b0; r.rd = '0; r.wen = 1'b0;
    case (op)
      3'd0: begin sum = 32'(a) + 32'(b); r.s = a + b; r.cout = (sum > 32'd65535);
                  sr = sa + sb; r.ovf = (sr > 32767) || (sr < -32768); end
      3'd1: begin r.s = a - b; r.cout = (a >= b);
                  sr = sa - sb; r.ovf = (sr > 32767) || (sr < -32768); end
      3'd2: r.s = a & b;
      3'd3: r.s = a | b;
      3'd4: r.s = a ^ b;
      3'd5: r.s = ~(a | b);
      3'd6: r.s = a << sh;
      default: r.s = a >> sh;
    endcase
    r.zero = (r.s == 16'd0);
    return r;
  endfunction

  // Operand value as the pipeline should see it.
  function automatic logic [15:0] src_val(input logic [2:0] idx, input logic [15:0] rf);
    if (idx == 3'd0) return 16'd0;
    if (m_valid && m_res.wen && m_res.rd == idx) return m_res.s;
    if (wb_wen && wb_rd == idx) return wb_val;
    return rf;
  endfunction

  // One clock of stimulus: inputs already set; predict, queue, advance.
  task automatic step();
    exp_t e;
    logic acc;
    logic [15:0] a, b;
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    if (m_valid) check("held_s", 32'(out_s), 32'(m_res.s));
    acc = in_valid && (!m_valid || out_ready);
    if (acc) begin
      a = src_val(in_rs, in_rs_val);
      b = in_use_imm ? in_imm : src_val(in_rt, in_rt_val);
      e = alu_ref(in_op, a, b);
      e.rd = in_rd;
      e.wen = in_wen;
    end
    if (flush) begin
      if (m_valid && !out_ready) void'(exp_q.pop_back());
      m_valid = 1'b0;
    end else if (acc) begin
      exp_q.push_back(e);
      m_valid = 1'b1;
      m_res = e;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [15:0] rsv, input logic [15:0] rtv, input logic [15:0] imm,
                        input logic use_imm, input logic [2:0] rd, input logic wen);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rs_val = rsv; in_rt_val = rtv;
    in_imm = imm; in_use_imm = use_imm; in_rd = rd; in_wen = wen;
  endtask

  // Monitor: every handed-off result must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_s), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_s", 32'(out_s), 32'(e.s));
        check("sb_cout", 32'(out_cout), 32'(e.cout));
        check("sb_zero", 32'(out_zero), 32'(e.zero));
        check("sb_rd", 32'(out_rd), 32'(e.rd));
        check("sb_wen", 32'(out_wen), 32'(e.wen));
`ifdef OVERFLOW_FLAG_EN
        check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(out_s), 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd1);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_wen", 32'(out_wen), 32'd0);
    rst_n = 1'b1;

    // ADD 0x7FFF + 5 via immediate, then hold under backpressure.
    out_ready = 1'b0;
    set_op(3'd0, 3'd1, 3'd0, 16'h7FFF, 16'h0000, 16'h0005, 1'b1, 3'd2, 1'b1);
    step();
    in_valid = 1'b0;
    check("add_s", 32'(out_s), 32'h8004);
    check("add_cout", 32'(out_cout), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check("add_ovf", 32'(out_ovf), 32'd1);
`endif
    step();

    // Asynchronous reset mid-hold drops the result immediately.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_zero", 32'(out_zero), 32'd1);
    exp_q.delete();
    m_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back RAW hazard: EX forward beats an active WB forward.
    out_ready = 1'b1;
    set_op(3'd0, 3'd2, 3'd3, 16'd3, 16'd4, 16'd0, 1'b0, 3'd1, 1'b1);
    step();
    check("raw_op1", 32'(out_s), 32'd7);
    set_op(3'd0, 3'd1, 3'd1, 16'd0, 16'd0, 16'd0, 1'b0, 3'd4, 1'b1);
    wb_wen = 1'b1; wb_rd = 3'd1; wb_val = 16'd9;
    step();
    check("raw_ex_fwd", 32'(out_s), 32'd14);

    // WB forward on rs, r0 on rt reads zero.
    set_op(3'd3, 3'd2, 3'd0, 16'h5555, 16'h1234, 16'd0, 1'b0, 3'd6, 1'b1);
    wb_rd = 3'd2; wb_val = 16'h00F0;
    step();
    check("wb_fwd", 32'(out_s), 32'h00F0);
    // wb_rd = 0 never forwards.
    set_op(3'd3, 3'd0, 3'd0, 16'hAAAA, 16'h1234, 16'd0, 1'b0, 3'd7, 1'b0);
    wb_rd = 3'd0; wb_val = 16'hFFFF;
    step();
    check("r0_s", 32'(out_s), 32'd0);
    check("r0_zero", 32'(out_zero), 32'd1);
    wb_wen = 1'b0;

    // Backpressure: three stalled cycles, then accept with no bubble.
    set_op(3'd0, 3'd3, 3'd0, 16'h0100, 16'd0, 16'd1, 1'b1, 3'd3, 1'b1);
    step();
    set_op(3'd0, 3'd5, 3'd0, 16'h0200, 16'd0, 16'd2, 1'b1, 3'd5, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_s", 32'(out_s), 32'h0101);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_s", 32'(out_s), 32'h0202);

    // Flush together with accept: nothing captured, nothing forwarded.
    set_op(3'd0, 3'd1, 3'd0, 16'h0011, 16'd0, 16'd0, 1'b0, 3'd5, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    set_op(3'd0, 3'd5, 3'd0, 16'h0022, 16'd0, 16'd0, 1'b0, 3'd6, 1'b1);
    step();
    check("flush_no_fwd", 32'(out_s), 32'h0022);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_op      = 3'($urandom_range(0, 7));
      in_rs      = 3'($urandom_range(0, 7));
      in_rt      = 3'($urandom_range(0, 7));
      in_rs_val  = 16'($urandom);
      in_rt_val  = 16'($urandom);
      in_imm     = 16'($urandom);
      in_use_imm = 1'($urandom_range(0, 1));
      in_rd      = 3'($urandom_range(0, 7));
      in_wen     = 1'($urandom_range(0, 1));
      wb_wen     = 1'($urandom_range(0, 1));
      wb_rd      = 3'($urandom_range(0, 7));
      wb_val     = 16'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain and confirm every prediction was delivered.
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
